// File: rtl/aurora_tx_scheduler_pkg.sv
// Shared Aurora framing definitions: opcodes, scheduler states and slot-count width.
// The receiver-side deframer imports this package too.
package aurora_tx_scheduler_pkg;

  localparam int SLOT_W = 18;

  localparam logic [3:0] OP_CTRL = 4'hC;
  localparam logic [3:0] OP_DATA = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_HDR,
    ST_DATA
  } tx_state_e;

endpackage

// File: rtl/aurora_credit_counter.sv
// Transmit credit: loads the partner advertisement minus a safety margin, then
// counts payload words down. It saturates at zero and never wraps.
module aurora_credit_counter
  import aurora_tx_scheduler_pkg::*;
#(
  parameter int CREDIT_MARGIN = 16
) (
  input  logic              user_clk,
  input  logic              rst_in,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [SLOT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic [SLOT_W-1:0] o_credit
);

  localparam logic [SLOT_W-1:0] MARGIN = SLOT_W'(CREDIT_MARGIN);
  localparam logic [SLOT_W-1:0] ONE    = SLOT_W'(1);

  logic [SLOT_W-1:0] r_credit;
  logic [SLOT_W-1:0] w_base;
  logic [SLOT_W-1:0] w_next;

  // A word sent in the same cycle as a fresh advertisement still costs one credit.
  always_comb begin
    w_base = r_credit;
    if (i_load) begin
      w_base = (i_load_val > MARGIN) ? (i_load_val - MARGIN) : '0;
    end
    w_next = w_base;
    if (i_dec && (w_base != '0)) begin
      w_next = w_base - ONE;
    end
  end

  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      r_credit <= '0;
    end else if (i_clear) begin
      r_credit <= '0;
    end else begin
      r_credit <= w_next;
    end
  end

  assign o_credit = r_credit;

endmodule

// File: rtl/aurora_tx_scheduler.sv
// Aurora TX scheduler. It sends periodic credit-advertisement words, and credit-limited
// data frames (a header followed by N words) taken from a first-word-fall-through FIFO.
module aurora_tx_scheduler
  import aurora_tx_scheduler_pkg::*;
#(
  parameter int BURST_MAX     = 256,
  parameter int CTRL_PERIOD   = 1024,
  parameter int CREDIT_MARGIN = 16
) (
  input  logic              user_clk,
  input  logic              rst_in,
  input  logic              channel_rdy,
  input  logic [31:0]       fifo_dat,
  input  logic              fifo_empty,
  input  logic [SLOT_W-1:0] fifo_cnt,
  output logic              fifo_rd,
  input  logic [SLOT_W-1:0] empty_slots,
  input  logic [SLOT_W-1:0] partner_empty_slots,
  input  logic              partner_empty_slots_valid,
  output logic [31:0]       tx_data,
  output logic              tx_data_src_rdy,
  input  logic              tx_data_dst_rdy,
  output logic [SLOT_W-1:0] credit
);

  localparam int                TMR_W     = (CTRL_PERIOD > 1) ? $clog2(CTRL_PERIOD) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CTRL_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [SLOT_W-1:0] BURST_CAP = SLOT_W'(BURST_MAX);
  localparam logic [SLOT_W-1:0] REM_ONE   = SLOT_W'(1);

  tx_state_e         r_state;
  logic [31:0]       r_tx_word;
  logic              r_src_rdy;
  logic              r_ctrl_pending;
  logic              r_chan_q;
  logic [TMR_W-1:0]  r_timer;
  logic [SLOT_W-1:0] r_rem;

  logic              w_src_rdy;
  logic              w_xfer;
  logic              w_pay_xfer;
  logic              w_ctrl_set;
  logic [SLOT_W-1:0] w_credit;
  logic [SLOT_W-1:0] w_burst;

  always_comb begin
    w_burst = fifo_cnt;
    if (w_credit < w_burst) w_burst = w_credit;
    if (BURST_CAP < w_burst) w_burst = BURST_CAP;
  end

  // In DATA the FIFO head drives the lane directly, so the first payload word
  // follows the header with no bubble. Dropping the lane gates the handshake at once.
  assign w_src_rdy  = channel_rdy & ((r_state == ST_DATA) ? ~fifo_empty : r_src_rdy);
  assign w_xfer     = w_src_rdy & tx_data_dst_rdy;
  assign w_pay_xfer = w_xfer & (r_state == ST_DATA);
  assign w_ctrl_set = (channel_rdy & ~r_chan_q) | (r_timer == TMR_LAST);

  assign tx_data         = (r_state == ST_DATA) ? fifo_dat : r_tx_word;
  assign tx_data_src_rdy = w_src_rdy;
  assign fifo_rd         = w_pay_xfer;
  assign credit          = w_credit;

  aurora_credit_counter #(
    .CREDIT_MARGIN(CREDIT_MARGIN)
  ) u_credit (
    .user_clk  (user_clk),
    .rst_in    (rst_in),
    .i_clear   (~channel_rdy),
    .i_load    (partner_empty_slots_valid),
    .i_load_val(partner_empty_slots),
    .i_dec     (w_pay_xfer),
    .o_credit  (w_credit)
  );

  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state        <= ST_IDLE;
      r_tx_word      <= '0;
      r_src_rdy      <= 1'b0;
      r_ctrl_pending <= 1'b1;
      r_chan_q       <= 1'b0;
      r_timer        <= '0;
      r_rem          <= '0;
    end else begin
      r_chan_q <= channel_rdy;
      if (!channel_rdy) begin
        r_state        <= ST_IDLE;
        r_src_rdy      <= 1'b0;
        r_ctrl_pending <= 1'b1;
        r_timer        <= '0;
        r_rem          <= '0;
      end else begin
        r_timer <= (r_timer == TMR_LAST) ? '0 : (r_timer + TMR_ONE);
        case (r_state)
          ST_IDLE: begin
            if (r_ctrl_pending) begin
              r_state   <= ST_CTRL;
              r_tx_word <= {OP_CTRL, 10'd0, empty_slots};
              r_src_rdy <= 1'b1;
            end else if ((w_credit != '0) && (fifo_cnt != '0)) begin
              r_state   <= ST_HDR;
              r_rem     <= w_burst;
              r_tx_word <= {OP_DATA, 12'd0, w_burst[15:0]};
              r_src_rdy <= 1'b1;
            end
          end
          ST_CTRL: begin
            if (w_xfer) begin
              r_state        <= ST_IDLE;
              r_src_rdy      <= 1'b0;
              r_ctrl_pending <= 1'b0;
            end
          end
          ST_HDR: begin
            if (w_xfer) begin
              r_state   <= ST_DATA;
              r_src_rdy <= 1'b0;
            end
          end
          ST_DATA: begin
            if (w_pay_xfer) begin
              r_rem <= r_rem - REM_ONE;
              if (r_rem == REM_ONE) r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        // A set request arriving in the same cycle as the CTRL handshake must survive.
        if (w_ctrl_set) r_ctrl_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/aurora_tx_scheduler.md
AURORA_TX_SCHEDULER -- requirements
Module: aurora_tx_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- BURST_MAX, 256, maximum payload words per data frame (1..65535).
- CTRL_PERIOD, 1024, user_clk cycles between credit-advertisement words.
- CREDIT_MARGIN, 16, words deducted from each partner advertisement to cover in-flight data.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- user_clk  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- channel_rdy  in  1  Aurora lane up.
- fifo_dat  in  32  head word of the first-word-fall-through prefetch FIFO.
- fifo_empty  in  1  prefetch FIFO empty.
- fifo_cnt  in  18  prefetch FIFO occupancy.
- fifo_rd  out  1  pop prefetch FIFO head.
- empty_slots  in  18  local receive-FIFO free slots, to be advertised.
- partner_empty_slots  in  18  partner free slots.
- partner_empty_slots_valid  in  1  one-cycle strobe for partner_empty_slots.
- tx_data  out  32  Aurora TX word.
- tx_data_src_rdy  out  1  tx_data valid.
- tx_data_dst_rdy  in  1  Aurora accepts word.
- credit  out  18  current transmit credit, for status.

Function
REQ-003 A word SHALL transfer on a rising user_clk edge with tx_data_src_rdy=1 and tx_data_dst_rdy=1; while src_rdy=1 and dst_rdy=0, tx_data SHALL hold stable.
REQ-004 Frame formats SHALL be as follows.
- CTRL word: [31:28]=4'hC, [27:18]=0, [17:0]=empty_slots, sampled when the CTRL state is entered.
- DATA header: [31:28]=4'hD, [27:16]=0, [15:0]=N.
- Payload: N raw words follow the header.
REQ-005 The FSM SHALL have states IDLE, CTRL, HDR and DATA.
- IDLE: src_rdy=0.
- IDLE->CTRL if ctrl_pending; otherwise IDLE->HDR if credit>=1 and fifo_cnt>=1, latching N=min(fifo_cnt, credit, BURST_MAX).
- CTRL->IDLE on transfer; ctrl_pending cleared.
- HDR->DATA on transfer.
- DATA: tx_data=fifo_dat, src_rdy=~fifo_empty, fifo_rd=src_rdy&dst_rdy (combinational). Remaining count decrements per transfer. DATA->IDLE on the transfer of the last word.
REQ-006 The header-to-first-payload transition SHALL have zero bubble cycles; a back-to-back stall-free N-word frame SHALL occupy N+1 consecutive cycles.
REQ-007 ctrl_pending SHALL be set when the cycle timer reaches CTRL_PERIOD-1 (the timer then wraps to 0) and on channel_rdy rising. ctrl_pending SHALL NOT preempt a frame in progress.
REQ-008 credit SHALL update as follows.
- On partner_empty_slots_valid: credit<=sat0(partner_empty_slots-CREDIT_MARGIN) minus 1 if a payload word transfers in the same cycle, floored at 0.
- Otherwise: credit decrements by 1 per payload transfer.
- credit SHALL never wrap below 0.
REQ-009 If fifo_empty rises mid-frame, the block SHALL stall in DATA with src_rdy=0; it SHALL NOT end the frame early.
REQ-010 While channel_rdy=0, the block SHALL act as follows.
- State forced to IDLE; src_rdy=0; fifo_rd=0.
- credit=0; timer=0; ctrl_pending=1.
- A frame interrupted mid-transfer is abandoned; the partner receiver discards it on its own channel reset.

Reset
REQ-011 While rst_in=1, the block SHALL hold these values: state IDLE, tx_data=0, tx_data_src_rdy=0, fifo_rd=0, credit=0, timer=0, ctrl_pending=1, remaining count=0.
REQ-012 After rst_in deasserts, the first word transmitted SHALL be a CTRL word.

Structure
REQ-013 A shared package SHALL hold the following.
- The opcode constants OP_CTRL=4'hC and OP_DATA=4'hD.
- The state enumeration.
- The 18-bit slot-count width constant.
- The package is shared with the receiver-side deframer.
REQ-014 The credit counter with its saturating load and decrement SHALL be one sub-module, aurora_credit_counter. All other logic SHALL be flat.

Verification
REQ-015 The bench SHALL cover these directed scenarios.
- Reset release, channel_rdy=1, empty_slots=18'h00800, dst_rdy=1 -> first word 32'hC0000800; credit=0; no DATA header.
- partner_empty_slots=100 strobed, fifo_cnt=40, BURST_MAX=256 -> credit=84; header 32'hD0000028, then 40 payload words in 41 consecutive cycles; credit=44.
- credit=10, fifo_cnt=50 -> N=10; credit=0; IDLE until the next partner strobe.
- dst_rdy toggled 1/0 each cycle during DATA -> tx_data stable on every stalled cycle; fifo_rd pulses only on accepted cycles; 100% payload order preserved.
- Timer expires mid-frame -> CTRL word sent immediately after the last payload word, never interleaved.
- channel_rdy dropped after 5 of 20 payload words -> src_rdy=0 next cycle; credit=0; on channel_rdy rise the first word is CTRL.
